uart_tx_fifo: RTL and testbench

Byte-oriented UART transmitter: the transmit-side counterpart of the team's UART receiver. A local 8-entry FIFO buffers bytes written by the host. The transmitter serialises each byte onto `tx` as start bit, 8 data bits LSB first, optional even parity, then one stop bit. Bit timing comes from an internal baud divider on the single system clock. This block drives the serial line that the receiver samples in the loopback and system benches.

---
 rtl/uart_tx_fifo.sv | 195 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte-wide UART transmitter with a local FIFO.
// Frames are start bit, 8 data bits LSB first, optional even parity, one stop bit.
// Bit timing comes from a baud counter running on the system clock.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int PARITY_EN    = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] d_in,
  output logic       tx,
  output logic       tx_full,
  output logic       tx_empty,
  output logic       tx_busy
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [PTR_W:0]    CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]    CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;

  // Frame engine
  state_t            r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;
  logic              r_parity;
  logic              r_tx;
  logic              r_busy;

  logic              w_full;
  logic              w_empty;
  logic              w_wr;
  logic              w_pop;
  logic              w_bit_done;
  logic              w_baud_clr;
  state_t            w_next_state;
  logic [7:0]        w_shift_next;
  logic              w_tx_next;

  assign w_full     = (r_count == CNT_FULL);
  assign w_empty    = (r_count == '0);
  // Full check uses the pre-edge count, so a pop on the same edge never frees a slot early.
  assign w_wr       = wr_en && !w_full;
  assign w_bit_done = (r_baud == BAUD_LAST);
  assign w_baud_clr = (r_state == S_IDLE) || w_bit_done || (w_next_state != r_state);

  assign tx       = r_tx;
  assign tx_busy  = r_busy;
  assign tx_full  = w_full;
  assign tx_empty = w_empty;

  // FIFO data array write port.
  // NOTE: the storage array has no reset; emptiness is tracked by the count and
  // pointers, so stale bytes are never read and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= d_in;
    end
  end

  // FIFO pointers and occupancy count.
  // NOTE: clocked state is always assigned with <= so every register samples
  // pre-edge values; a blocking = here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Next-state, pop decision and next line value for the frame engine.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_shift_next = r_shift;
    w_tx_next    = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = S_START;
        end
      end
      S_START: begin
        if (w_bit_done) begin
          w_next_state = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_done) begin
          w_shift_next = r_shift >> 1;
          if (r_bit_idx == 3'd7) begin
            w_next_state = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_done) begin
          w_next_state = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bit_done) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_next_state = S_START;
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase

    if (w_pop) begin
      w_shift_next = r_mem[r_rd_ptr];
    end

    // The line value is decoded from the upcoming state so tx can be a plain register.
    case (w_next_state)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = w_shift_next[0];
      S_PARITY: w_tx_next = r_parity;
      default:  w_tx_next = 1'b1;
    endcase
  end

  // Frame engine registers: state, baud counter, bit index, shifter and line outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
      r_busy  <= (w_next_state != S_IDLE);

      if (w_baud_clr) begin
        r_baud <= '0;
      end else begin
        r_baud <= r_baud + BAUD_ONE;
      end

      if (w_pop) begin
        r_bit_idx <= '0;
        r_parity  <= ^r_mem[r_rd_ptr];
      end else if (r_state == S_DATA && w_bit_done) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: two transmitters (no parity / even parity) driven by the same
// host stimulus, each checked every cycle against a queue-based frame model,
// plus directed literal checks on hand-computed line waveforms.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] d_in  = 8'h00;

  logic tx0, full0, empty0, busy0;
  logic tx1, full1, empty1, busy1;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_EN(0)) dut0 (
    .clk(clk), .reset(rst_n), .wr_en(wr_en), .d_in(d_in),
    .tx(tx0), .tx_full(full0), .tx_empty(empty0), .tx_busy(busy0)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_EN(1)) dut1 (
    .clk(clk), .reset(rst_n), .wr_en(wr_en), .d_in(d_in),
    .tx(tx1), .tx_full(full1), .tx_empty(empty1), .tx_busy(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus a queue holding the per-cycle line values
  // of the frame being sent. Updated on each clock edge from pre-edge inputs.
  for (genvar g = 0; g < 2; g++) begin : g_model
    localparam int P = g;
    logic [7:0] q[$];
    logic       line[$];
    logic       fr[$];
    logic       exp_tx    = 1'b1;
    logic       exp_busy  = 1'b0;
    logic       exp_empty = 1'b1;
    logic       exp_full  = 1'b0;

    initial begin : model_proc
      logic [7:0] b;
      logic       pre_full;
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          q.delete();
          line.delete();
        end else begin
          pre_full = (q.size() == DEPTH);
          if (line.size() != 0) void'(line.pop_front());
          if (line.size() == 0 && q.size() != 0) begin
            b = q.pop_front();
            fr.delete();
            fr.push_back(1'b0);
            for (int i = 0; i < 8; i++) fr.push_back(b[i]);
            if (P != 0) fr.push_back(^b);
            fr.push_back(1'b1);
            foreach (fr[i]) for (int c = 0; c < CPB; c++) line.push_back(fr[i]);
          end
          if (wr_en && !pre_full) q.push_back(d_in);
        end
        exp_tx    = (line.size() != 0) ? line[0] : 1'b1;
        exp_busy  = (line.size() != 0);
        exp_empty = (q.size() == 0);
        exp_full  = (q.size() == DEPTH);
      end
    end
  end

  // Compare process: every cycle out of reset, both DUTs against their models.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        check("model tx0",    tx0,    g_model[0].exp_tx);
        check("model busy0",  busy0,  g_model[0].exp_busy);
        check("model empty0", empty0, g_model[0].exp_empty);
        check("model full0",  full0,  g_model[0].exp_full);
        check("model tx1",    tx1,    g_model[1].exp_tx);
        check("model busy1",  busy1,  g_model[1].exp_busy);
        check("model empty1", empty1, g_model[1].exp_empty);
        check("model full1",  full1,  g_model[1].exp_full);
      end
    end
  end

  // Line decoder for the no-parity DUT; frames cut by reset are discarded.
  logic [7:0] rx_q[$];
  int         rst_epoch = 0;

  initial forever begin
    @(negedge rst_n);
    rst_epoch++;
  end

  initial begin : decoder
    logic [7:0] b;
    int         ep;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx0 === 1'b0) begin
        ep = rst_epoch;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          b[k] = tx0;
        end
        repeat (CPB) @(negedge clk);
        if (tx0 === 1'b1 && ep == rst_epoch) rx_q.push_back(b);
        @(negedge clk);
      end
    end
  end

  // Per-cycle capture of both lines, starting at the cycle after a pop edge.
  logic cap0 [48];
  logic cap1 [48];
  logic bz0  [48];
  logic bz1  [48];
  logic em0  [48];

  task automatic capture();
    for (int k = 0; k < 48; k++) begin
      cap0[k] = tx0;
      cap1[k] = tx1;
      bz0[k]  = busy0;
      bz1[k]  = busy1;
      em0[k]  = empty0;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(busy0 === 1'b0 && empty0 === 1'b1 && busy1 === 1'b0 && empty1 === 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_idle: still busy after %0d cycles, expected idle", budget);
    end
    repeat (3) @(negedge clk);
  endtask

  // Write one byte at the next edge; returns at the cycle after the pop edge.
  task automatic send_one(input logic [7:0] b);
    wr_en = 1'b1;
    d_in  = b;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [9:0] a5_bits;
    a5_bits = 10'b1101001010;  // bit k = line value of frame bit k for 0xA5

    // Reset state, checked while reset is held.
    repeat (3) @(negedge clk);
    check("reset tx",    tx0,    1'b1);
    check("reset busy",  busy0,  1'b0);
    check("reset empty", empty0, 1'b1);
    check("reset full",  full0,  1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0xA5.
    wr_en = 1'b1;
    d_in  = 8'hA5;
    @(negedge clk);
    wr_en = 1'b0;
    check("a5 empty after write", empty0, 1'b0);
    check("a5 tx idle before pop", tx0, 1'b1);
    @(negedge clk);
    check("a5 empty after pop", empty0, 1'b1);
    check("a5 busy after pop", busy0, 1'b1);
    capture();
    for (int k = 0; k < 40; k++) begin
      check($sformatf("a5 bit cycle %0d", k), cap0[k], a5_bits[k / CPB]);
    end
    check("a5 busy last stop", bz0[39], 1'b1);
    check("a5 busy after frame", bz0[40], 1'b0);
    check("a5 tx after frame", cap0[40], 1'b1);
    wait_idle(200);

    // Back-to-back 0x00 then 0xFF.
    wr_en = 1'b1;
    d_in  = 8'h00;
    @(negedge clk);
    d_in  = 8'hFF;
    @(negedge clk);
    wr_en = 1'b0;
    check("b2b second byte buffered", empty0, 1'b0);
    capture();
    check("b2b 00 d7", cap0[35], 1'b0);
    check("b2b 00 stop first", cap0[36], 1'b1);
    check("b2b 00 stop last", cap0[39], 1'b1);
    check("b2b ff start no gap", cap0[40], 1'b0);
    check("b2b ff d0", cap0[44], 1'b1);
    check("b2b empty before 2nd pop", em0[39], 1'b0);
    check("b2b empty after 2nd pop", em0[40], 1'b1);
    wait_idle(300);

    // Overflow: ten writes on consecutive edges while idle.
    rx_q.delete();
    for (int i = 1; i <= 10; i++) begin
      wr_en = 1'b1;
      d_in  = 8'(i);
      @(negedge clk);
      if (i == 2) check("ovf pop at edge 2", tx0, 1'b0);
      if (i == 8) check("ovf full after edge 8", full0, 1'b0);
      if (i == 9) check("ovf full after edge 9", full0, 1'b1);
      if (i == 9) check("ovf full1 after edge 9", full1, 1'b1);
      if (i == 10) check("ovf full after dropped write", full0, 1'b1);
    end
    wr_en = 1'b0;
    wait_idle(2000);
    check("ovf byte count", rx_q.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < rx_q.size()) check($sformatf("ovf byte %0d", i), rx_q[i], i + 1);
    end

    // Parity: 0x07 has odd weight, 0x03 even weight.
    send_one(8'h07);
    capture();
    check("par07 start", cap1[0], 1'b0);
    check("par07 d7", cap1[32], 1'b0);
    check("par07 parity", cap1[36], 1'b1);
    check("par07 stop", cap1[40], 1'b1);
    check("par07 busy last cycle", bz1[43], 1'b1);
    check("par07 frame 44 cycles", bz1[44], 1'b0);
    wait_idle(200);
    send_one(8'h03);
    capture();
    check("par03 d1", cap1[8], 1'b1);
    check("par03 parity", cap1[36], 1'b0);
    check("par03 stop", cap1[40], 1'b1);
    wait_idle(200);

    // Reset during data bit 4 of the first of three frames.
    rx_q.delete();
    wr_en = 1'b1;
    d_in  = 8'h0F;
    @(negedge clk);
    d_in  = 8'h22;
    @(negedge clk);
    d_in  = 8'h33;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (20) @(negedge clk);
    check("rst mid d4 line low", tx0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst async tx", tx0, 1'b1);
    check("rst async busy", busy0, 1'b0);
    check("rst async empty", empty0, 1'b1);
    check("rst async tx1", tx1, 1'b1);
    check("rst async empty1", empty1, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("rst no resume tx", tx0, 1'b1);
    check("rst no resume busy", busy0, 1'b0);
    check("rst no resume frames", rx_q.size(), 0);
    send_one(8'h5A);
    wait_idle(200);
    check("rst new byte count", rx_q.size(), 1);
    if (rx_q.size() != 0) check("rst new byte", rx_q[0], 8'h5A);

    // Write/pop collision while full.
    rx_q.delete();
    send_one(8'h80);
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1;
      d_in  = 8'(8'h80 + i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    check("coll full after fill", full0, 1'b1);
    repeat (31) @(negedge clk);
    check("coll full before pop edge", full0, 1'b1);
    check("coll last stop cycle", tx0, 1'b1);
    wr_en = 1'b1;
    d_in  = 8'hEE;
    @(negedge clk);
    wr_en = 1'b0;
    check("coll full after pop edge", full0, 1'b0);
    check("coll next start", tx0, 1'b0);
    check("coll full1 still full", full1, 1'b1);
    wait_idle(2000);
    check("coll byte count", rx_q.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < rx_q.size()) check($sformatf("coll byte %0d", i), rx_q[i], 8'h80 + i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
